// File: rtl/bcd_ex3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_ex3_pkg
// Description : Shared constants, FSM state type and digit-validity helper
//               for the BCD <-> Excess-3 conversion blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_ex3_pkg;

  // Excess-3 bias added to every valid BCD digit
  localparam logic [3:0] EX3_OFFSET  = 4'd3;
  // Code emitted in place of a non-BCD source digit
  localparam logic [3:0] EX3_INVALID = 4'b1111;

  // Serializer states: IDLE waits for a word, SEND streams its digits
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A BCD digit is legal only in the range 0..9
  function automatic logic bcd_digit_valid(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_ex3_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_ex3_digit
// Description : Combinational single-digit BCD to Excess-3 encoder. Illegal
//               BCD codes (1010..1111) map to EX3_INVALID and raise o_err.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_ex3_digit
  import bcd_ex3_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [3:0] o_ex3,
  output logic       o_err
);

  // Add the Excess-3 bias (4-bit wrap) or substitute the invalid code
  always_comb begin
    o_err = !bcd_digit_valid(i_bcd);
    o_ex3 = o_err ? EX3_INVALID : (i_bcd + EX3_OFFSET);
  end

endmodule
`default_nettype wire

// File: rtl/bcd_to_ex3_ser.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_ex3_ser
// Description : Accepts a packed NDIG-digit BCD word over a valid/ready
//               handshake and streams it out one Excess-3 digit per transfer,
//               least-significant digit first, flagging the last digit and
//               any illegal source digit.
// Options     : define BCD_TO_EX3_PARITY_EN to add out_par (odd parity over
//               out_ex3).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_ex3_ser
  import bcd_ex3_pkg::*;
#(
  parameter int NDIG = 4
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_bcd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_ex3,
  output logic              out_last,
  output logic              out_err,
`ifdef BCD_TO_EX3_PARITY_EN
  output logic              out_par,
`endif
  output logic              busy
);

  localparam int               IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [4*NDIG-1:0] r_word;
  logic [IDX_W-1:0]  r_idx;
  logic              w_accept;
  logic              w_xfer;
  logic              w_at_last;
  logic [3:0]        w_digit;
  logic [3:0]        w_ex3;
  logic              w_err;

  assign w_at_last = (r_idx == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; rst masks the handshakes so a
  // same-cycle transfer can never slip past a reset
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_xfer      = 1'b0;
    if (rst) begin
      in_ready    = 1'b1;
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = SEND;
          end
        end
        SEND: begin
          out_valid = 1'b1;
          busy      = 1'b1;
          if (out_ready) begin
            w_xfer = 1'b1;
            if (w_at_last) begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Held word and digit index; the index wraps to 0 after the last digit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_word <= in_bcd;
      r_idx  <= '0;
    end else if (w_xfer) begin
      r_idx  <= w_at_last ? '0 : (r_idx + IDX_W'(1));
    end
  end

  // Select the current BCD digit from the held word
  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_digit = r_word[4*i +: 4];
      end
    end
  end

  bcd_ex3_digit u_digit (
    .i_bcd (w_digit),
    .o_ex3 (w_ex3),
    .o_err (w_err)
  );

  // Digit outputs are zero whenever no digit is being presented
  always_comb begin
    out_ex3  = out_valid ? w_ex3 : 4'd0;
    out_last = out_valid & w_at_last;
    out_err  = out_valid & w_err;
  end

`ifdef BCD_TO_EX3_PARITY_EN
  // Odd parity: total ones across out_ex3 and out_par is odd
  always_comb begin
    out_par = out_valid & ~(^w_ex3);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_ex3_ser.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_ex3_ser
// Description : Self-checking bench for bcd_to_ex3_ser (NDIG=4) using an
//               expected-digit queue filled at acceptance time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_ex3_ser;

  localparam int NDIG = 4;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic [15:0] in_bcd    = 16'h0000;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out_ex3;
  logic        out_last;
  logic        out_err;
  logic        busy;
`ifdef BCD_TO_EX3_PARITY_EN
  logic        out_par;
`endif

  typedef struct packed {
    logic [3:0] ex3;
    logic       last;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bcd_to_ex3_ser #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ex3   (out_ex3),
    .out_last  (out_last),
    .out_err   (out_err),
`ifdef BCD_TO_EX3_PARITY_EN
    .out_par   (out_par),
`endif
    .busy      (busy)
  );

  // Reference encoding of one digit
  function automatic exp_t model_digit(input logic [3:0] d, input logic last);
    exp_t e;
    e.last = last;
    if (d > 4'd9) begin
      e.ex3 = 4'b1111;
      e.err = 1'b1;
    end else begin
      e.ex3 = d + 4'd3;
      e.err = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // first output cycle with in_valid dropped and in_bcd scrambled.
  task automatic accept_word(input logic [15:0] w);
    logic [3:0] d;
    in_valid = 1'b1;
    in_bcd   = w;
    for (int i = 0; i < NDIG; i++) begin
      d = w[4*i +: 4];
      sb.push_back(model_digit(d, (i == NDIG - 1)));
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_bcd   = ~w;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_bcd    = 16'h1234;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, out_ex3, out_last, out_err, busy} !== 9'b1_0_0000_0_0_0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b ex3=%b last=%b err=%b busy=%b want 1 0 0000 0 0 0",
               in_ready, out_valid, out_ex3, out_last, out_err, busy);
    end
`ifdef BCD_TO_EX3_PARITY_EN
    n_tests++;
    if (out_par !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_par: got %b want 0", out_par);
    end
`endif
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_exit_idle: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    out_ready = 1'b1;
    accept_word(16'h1234);
    for (int c = 0; c < NDIG; c++) begin
      n_tests++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_hs[%0d]: got vld=%b busy=%b rdy=%b want 1 1 0", c, out_valid, busy, in_ready);
      end
      e = sb.pop_front();
      n_tests++;
      if ({out_ex3, out_last, out_err} !== {e.ex3, e.last, e.err}) begin
        n_fail++;
        $display("FAIL basic_digit[%0d]: got ex3=%b last=%b err=%b want %b %b %b",
                 c, out_ex3, out_last, out_err, e.ex3, e.last, e.err);
      end
      @(negedge clk);
    end
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_return: got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  // 0000 then 9999 with no idle gap beyond the mandatory one cycle
  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] words [2];
    words[0] = 16'h0000;
    words[1] = 16'h9999;
    out_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      accept_word(words[w]);
      for (int c = 0; c < NDIG; c++) begin
        e = sb.pop_front();
        n_tests++;
        if (out_valid !== 1'b1 || {out_ex3, out_last, out_err} !== {e.ex3, e.last, e.err}) begin
          n_fail++;
          $display("FAIL b2b_digit[%0d.%0d]: got vld=%b ex3=%b last=%b err=%b want 1 %b %b %b",
                   w, c, out_valid, out_ex3, out_last, out_err, e.ex3, e.last, e.err);
        end
        @(negedge clk);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", w, in_ready);
      end
    end
  endtask

  // Invalid digit A at index 1; in_valid kept high with junk during SEND
  task automatic test_invalid();
    exp_t e;
    out_ready = 1'b1;
    accept_word(16'h12A4);
    in_valid = 1'b1;
    for (int c = 0; c < NDIG; c++) begin
      if (c == NDIG - 1) in_valid = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || {out_ex3, out_last, out_err} !== {e.ex3, e.last, e.err}) begin
        n_fail++;
        $display("FAIL invalid_digit[%0d]: got vld=%b ex3=%b last=%b err=%b want 1 %b %b %b",
                 c, out_valid, out_ex3, out_last, out_err, e.ex3, e.last, e.err);
      end
      @(negedge clk);
    end
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_return: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  // out_ready low for three cycles while digit 1 is presented
  task automatic test_backpressure();
    exp_t e;
    logic r;
    out_ready = 1'b1;
    accept_word(16'h5678);
    for (int k = 0; k < NDIG + 3; k++) begin
      r = !(k >= 1 && k <= 3);
      out_ready = r;
      e = sb[0];
      n_tests++;
      if (out_valid !== 1'b1 || {out_ex3, out_last, out_err} !== {e.ex3, e.last, e.err}) begin
        n_fail++;
        $display("FAIL bp_digit[%0d]: got vld=%b ex3=%b last=%b err=%b want 1 %b %b %b",
                 k, out_valid, out_ex3, out_last, out_err, e.ex3, e.last, e.err);
      end
      if (k >= 1 && k <= 3) begin
        n_tests++;
        if (out_ex3 !== 4'b1010) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: got %b want 1010", k, out_ex3);
        end
      end
      if (r) void'(sb.pop_front());
      @(negedge clk);
    end
    out_ready = 1'b1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_return: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midword();
    exp_t e;
    out_ready = 1'b1;
    accept_word(16'h4321);
    for (int c = 0; c < 3; c++) begin
      e = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || {out_ex3, out_last, out_err} !== {e.ex3, e.last, e.err}) begin
        n_fail++;
        $display("FAIL rstmid_digit[%0d]: got vld=%b ex3=%b want 1 %b", c, out_valid, out_ex3, e.ex3);
      end
      if (c < 2) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    n_tests++;
    if ({out_valid, in_ready, busy, out_ex3, out_last} !== 8'b0_1_0_0000_0) begin
      n_fail++;
      $display("FAIL rstmid_after: got vld=%b rdy=%b busy=%b ex3=%b last=%b want 0 1 0 0000 0",
               out_valid, in_ready, busy, out_ex3, out_last);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_resume: got vld=%b want 0", out_valid);
    end
    accept_word(16'h0009);
    for (int c = 0; c < NDIG; c++) begin
      e = sb.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || {out_ex3, out_last, out_err} !== {e.ex3, e.last, e.err}) begin
        n_fail++;
        $display("FAIL rstmid_next[%0d]: got vld=%b ex3=%b last=%b err=%b want 1 %b %b %b",
                 c, out_valid, out_ex3, out_last, out_err, e.ex3, e.last, e.err);
      end
      @(negedge clk);
    end
  endtask

  // Random words (including illegal nibbles) with random backpressure
  task automatic test_random();
    exp_t        e;
    logic [15:0] word;
    logic        r;
    int          got;
    int          cyc;
    for (int w = 0; w < 8; w++) begin
      word = 16'($urandom);
      out_ready = 1'b1;
      accept_word(word);
      got = 0;
      cyc = 0;
      while (got < NDIG && cyc < 60) begin
        r = 1'($urandom_range(0, 1));
        n_tests++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
          n_fail++;
          $display("FAIL rand_valid[%0d]: got vld=%b want 1 (word %h)", w, out_valid, word);
        end else begin
          e = sb[0];
          n_tests++;
          if ({out_ex3, out_last, out_err} !== {e.ex3, e.last, e.err}) begin
            n_fail++;
            $display("FAIL rand_digit[%0d.%0d]: got ex3=%b last=%b err=%b want %b %b %b (word %h)",
                     w, got, out_ex3, out_last, out_err, e.ex3, e.last, e.err, word);
          end
        end
        out_ready = r;
        if (r) begin
          void'(sb.pop_front());
          got++;
        end
        @(negedge clk);
        cyc++;
      end
      out_ready = 1'b1;
      n_tests++;
      if (got < NDIG || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_done[%0d]: got digits=%0d rdy=%b want %0d 1", w, got, in_ready, NDIG);
        sb.delete();
        repeat (NDIG + 2) @(negedge clk);
      end
    end
  endtask

`ifdef BCD_TO_EX3_PARITY_EN
  task automatic test_parity();
    exp_t e;
    out_ready = 1'b1;
    accept_word(16'h0004);
    for (int c = 0; c < NDIG; c++) begin
      e = sb.pop_front();
      n_tests++;
      if (out_ex3 !== e.ex3 || out_par !== ~(^e.ex3)) begin
        n_fail++;
        $display("FAIL parity[%0d]: got ex3=%b par=%b want %b %b", c, out_ex3, out_par, e.ex3, ~(^e.ex3));
      end
      if (c == 0) begin
        n_tests++;
        if (out_par !== 1'b0) begin
          n_fail++;
          $display("FAIL parity_0111: got %b want 0", out_par);
        end
      end
      if (c == 1) begin
        n_tests++;
        if (out_par !== 1'b1) begin
          n_fail++;
          $display("FAIL parity_0011: got %b want 1", out_par);
        end
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_invalid();
    test_backpressure();
    test_reset_midword();
    test_random();
`ifdef BCD_TO_EX3_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
